// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with exception flush
package cpu_design_params;
  localparam int NUM_A_REGS = 32;
  localparam int NUM_P_REGS = 64;
  localparam int PRN_WIDTH  = $clog2(NUM_P_REGS);
endpackage

module reorder_buffer
  import cpu_design_params::*;
#(
  parameter int ROB_DEPTH = 16,
  localparam int IDX_W  = $clog2(ROB_DEPTH),
  localparam int AREG_W = $clog2(NUM_A_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic                 alloc_has_dest,
  input  logic [AREG_W-1:0]    alloc_areg,
  input  logic [PRN_WIDTH-1:0] alloc_preg,
  input  logic [PRN_WIDTH-1:0] alloc_old_preg,
  output logic [IDX_W-1:0]     alloc_rob_idx,
  input  logic                 complete_valid,
  input  logic [IDX_W-1:0]     complete_rob_idx,
  input  logic                 complete_exc,
  output logic                 commit_valid,
  output logic [AREG_W-1:0]    commit_areg,
  output logic [PRN_WIDTH-1:0] commit_preg,
  output logic                 free_valid,
  output logic [PRN_WIDTH-1:0] free_preg,
  output logic                 flush_valid,
  output logic [IDX_W:0]       count
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [IDX_W:0] PTR_ONE = 1;

  state_t state, state_next;
  logic [IDX_W:0]   head_ptr, tail_ptr;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             empty, full;

  logic [ROB_DEPTH-1:0] valid, done, exc, has_dest;
  logic [AREG_W-1:0]    areg     [ROB_DEPTH];
  logic [PRN_WIDTH-1:0] preg     [ROB_DEPTH];
  logic [PRN_WIDTH-1:0] old_preg [ROB_DEPTH];

  logic head_done, do_alloc, do_retire;

  assign head_idx = head_ptr[IDX_W-1:0];
  assign tail_idx = tail_ptr[IDX_W-1:0];
  assign empty    = (head_ptr == tail_ptr);
  assign full     = (head_idx == tail_idx) && (head_ptr[IDX_W] != tail_ptr[IDX_W]);

  assign alloc_ready   = !full && (state == RUN);
  assign alloc_rob_idx = tail_idx;
  assign count         = tail_ptr - head_ptr;
  assign flush_valid   = (state == FLUSH);
  assign do_alloc      = alloc_valid && alloc_ready;
  assign head_done     = !empty && valid[head_idx] && done[head_idx];

  always_comb begin
    state_next = state;
    do_retire  = 1'b0;
    case (state)
      RUN: begin
        if (head_done) begin
          if (exc[head_idx]) state_next = FLUSH;
          else               do_retire  = 1'b1;
        end
      end
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      head_ptr     <= '0;
      tail_ptr     <= '0;
      valid        <= '0;
      commit_valid <= 1'b0;
      free_valid   <= 1'b0;
      commit_areg  <= '0;
      commit_preg  <= '0;
      free_preg    <= '0;
    end else begin
      state        <= state_next;
      commit_valid <= do_retire;
      free_valid   <= do_retire && has_dest[head_idx];
      if (do_retire) begin
        commit_areg <= areg[head_idx];
        commit_preg <= preg[head_idx];
        free_preg   <= old_preg[head_idx];
      end

      if (state == FLUSH) begin
        // Speculative physical registers are recovered by rename, not here.
        valid    <= '0;
        head_ptr <= '0;
        tail_ptr <= '0;
      end else begin
        if (complete_valid && valid[complete_rob_idx]) begin
          done[complete_rob_idx] <= 1'b1;
          exc[complete_rob_idx]  <= complete_exc;
        end
        if (do_alloc) begin
          valid[tail_idx]    <= 1'b1;
          done[tail_idx]     <= 1'b0;
          exc[tail_idx]      <= 1'b0;
          has_dest[tail_idx] <= alloc_has_dest;
          areg[tail_idx]     <= alloc_areg;
          preg[tail_idx]     <= alloc_preg;
          old_preg[tail_idx] <= alloc_old_preg;
          tail_ptr           <= tail_ptr + PTR_ONE;
        end
        // Head and tail never alias here: a retiring head implies non-empty,
        // and a full buffer blocks allocation.
        if (do_retire) begin
          valid[head_idx] <= 1'b0;
          head_ptr        <= head_ptr + PTR_ONE;
        end
      end
    end
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, number of in-flight entries (power of two, at least 4).
REQ-002 SHALL take NUM_A_REGS, NUM_P_REGS and PRN_WIDTH from cpu_design_params, and SHALL define IDX_W = log2(ROB_DEPTH).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port alloc_valid, input, 1, rename stage presents a renamed instruction.
REQ-006 SHALL have port alloc_ready, output, 1, entry can be accepted this cycle.
REQ-007 SHALL have port alloc_has_dest, input, 1, instruction writes an architectural register.
REQ-008 SHALL have port alloc_areg, input, log2(NUM_A_REGS), destination architectural register.
REQ-009 SHALL have port alloc_preg, input, PRN_WIDTH, newly mapped physical register.
REQ-010 SHALL have port alloc_old_preg, input, PRN_WIDTH, previous mapping of alloc_areg.
REQ-011 SHALL have port alloc_rob_idx, output, IDX_W, index assigned to the accepted entry (current tail).
REQ-012 SHALL have port complete_valid, input, 1, execution writeback for one entry.
REQ-013 SHALL have port complete_rob_idx, input, IDX_W, entry being completed.
REQ-014 SHALL have port complete_exc, input, 1, completed instruction raised an exception.
REQ-015 SHALL have port commit_valid, output, 1, registered one-cycle pulse per retired entry.
REQ-016 SHALL have port commit_areg, output, log2(NUM_A_REGS), retired destination architectural register.
REQ-017 SHALL have port commit_preg, output, PRN_WIDTH, retired destination physical register.
REQ-018 SHALL have port free_valid, output, 1, alloc_old_preg of the retired entry is returned to the free list.
REQ-019 SHALL have port free_preg, output, PRN_WIDTH, physical register being freed.
REQ-020 SHALL have port flush_valid, output, 1, one-cycle pulse signalling a pipeline flush.
REQ-021 SHALL have port count, output, IDX_W+1, number of valid entries.

Function
REQ-022 SHALL be a circular buffer with head_ptr and tail_ptr of IDX_W+1 bits each (MSB used as the wrap bit), and SHALL store per entry: valid, done, exc, has_dest, areg, preg, old_preg.
REQ-023 SHALL be empty when head_ptr == tail_ptr, and full when the low IDX_W bits are equal and the wrap bits differ.
REQ-024 SHALL drive alloc_ready = !full && state==RUN, computed from the current-cycle count only (no same-cycle bypass of a retiring entry).
REQ-025 SHALL, on alloc_valid && alloc_ready, write the entry at tail with valid=1, done=0, exc=0, then increment tail_ptr modulo 2*ROB_DEPTH.
REQ-026 SHALL, on complete_valid, set done=1 and exc=complete_exc for the addressed entry only if that entry is valid; otherwise SHALL ignore the completion.
REQ-027 SHALL, in RUN, retire at most one entry per cycle; the head entry retires when valid && done && !exc.
REQ-028 SHALL, on retirement, register commit_valid=1 together with commit_areg and commit_preg for the next cycle, clear the head entry and increment head_ptr.
REQ-029 SHALL, on retirement, drive free_valid = has_dest and free_preg = old_preg in the same cycle as commit_valid; free_valid SHALL be 0 when has_dest=0.
REQ-030 SHALL assert commit_valid in cycle N+2 for a completion sampled at the edge ending cycle N on the head entry (latency 2).
REQ-031 SHALL allow allocate, complete and retire in the same cycle, updating count by (+1 alloc, -1 retire).
REQ-032 SHALL implement an FSM with states RUN and FLUSH: RUN moves to FLUSH when the head entry is valid && done && exc; FLUSH moves to RUN after exactly one cycle.
REQ-033 SHALL, on entering FLUSH, not commit the excepting entry; in FLUSH it SHALL pulse flush_valid, clear every valid bit, set head_ptr=tail_ptr=0, deassert alloc_ready and ignore completions.
REQ-034 SHALL NOT return speculative physical registers on flush; free-list recovery belongs to the rename stage.
REQ-035 SHALL make an alloc_valid that arrives while alloc_ready=0 have no effect; the upstream holds the request.
REQ-036 SHALL handle pointer wrap-around so that an entry allocated after wrap retires in program order.

Reset
REQ-037 SHALL, on rst at a rising edge, set state=RUN, head_ptr=tail_ptr=0 and all valid bits=0, and SHALL drive commit_valid, free_valid, flush_valid and count to 0 and alloc_ready to 1 in the following cycle.
REQ-038 SHALL give rst priority over all simultaneous alloc, complete and flush activity; an assertion mid-flush SHALL return the block to RUN with the buffer empty.

Verification
REQ-039 SHALL be verified by basic retire: alloc areg=3, preg=40, old_preg=3, then complete idx 0 -> commit_valid in cycle N+2 with commit_areg=3, commit_preg=40, free_preg=3, count back to 0.
REQ-040 SHALL be verified by full and in-order retire: 16 allocs with no completes -> alloc_ready=0 and count=16; complete idx 5 then idx 0 -> only idx 0 retires; idx 5 waits at head until 1 through 4 are done.
REQ-041 SHALL be verified by the exception path: alloc 3 entries, complete idx 0 with complete_exc=1 -> no commit_valid, one-cycle flush_valid, then count=0 and alloc_ready=1.
REQ-042 SHALL be verified by wrap-around: 40 alloc/complete pairs streamed -> 40 commits in order, alloc_rob_idx sequence 0..15,0..15,0..7.
REQ-043 SHALL be verified by no-dest and stale completes: alloc with has_dest=0 -> commit_valid=1 and free_valid=0; complete to an unallocated idx -> no state change.
REQ-044 SHALL be verified by reset mid-operation: assert rst with 10 entries valid -> next cycle count=0, alloc_ready=1 and all pulse outputs 0.
